// File: rtl/seu_npu_pkg.sv
// Shared types and defaults for the NPU enable/busy launch handshake.
// MIN_LOW_DEF is also used by the clk_cal-side NPU core.
package seu_npu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_READY = 3'd2,
        ST_START = 3'd3,
        ST_RUN   = 3'd4,
        ST_COOL  = 3'd5,
        ST_ERR   = 3'd6
    } state_e;

    localparam int INIT_LEN_W_DEF = 16;
    localparam int TO_W_DEF       = 20;
    localparam int TO_CYCLES_DEF  = 1000000;
    localparam int MIN_LOW_DEF    = 4;

    // Init data stays valid from the end of a load until a re-init or an abort.
    function automatic logic init_held(input state_e s);
        return (s == ST_READY) || (s == ST_START) || (s == ST_RUN) || (s == ST_COOL);
    endfunction

    function automatic logic en_held(input state_e s);
        return (s == ST_START) || (s == ST_RUN);
    endfunction

endpackage

// File: rtl/seu_npu_timeout_cnt.sv
// Clear/enable down-counter: clr reloads LOAD, en counts down to zero,
// expire is high while enabled with the count at zero.
module seu_npu_timeout_cnt
    import seu_npu_pkg::*;
#(
    parameter int           W    = TO_W_DEF,
    parameter logic [W-1:0] LOAD = '1
) (
    input  logic clk_trans,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [W-1:0] cnt;

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_trans) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= LOAD;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign expire = en && !clr && (cnt == '0);

endmodule

// File: rtl/seu_npu_launch_ctrl.sv
// clk_trans-side initiator of the NPU enable/busy 4-phase handshake: init load,
// run launch and completion. Define SEU_NPU_TIMEOUT_EN to add the START/RUN timeout abort.
module seu_npu_launch_ctrl
    import seu_npu_pkg::*;
#(
    parameter int INIT_LEN_W = INIT_LEN_W_DEF,
    parameter int MIN_LOW    = MIN_LOW_DEF,
    parameter int TO_W       = TO_W_DEF,
    parameter int TO_CYCLES  = TO_CYCLES_DEF
) (
    input  logic                  clk_trans,
    input  logic                  rst,
    input  logic                  init_req,
    input  logic [INIT_LEN_W-1:0] init_len,
    input  logic                  init_wvalid,
    output logic                  init_wready,
    output logic                  npu_init_cmplt,
    input  logic                  run_req,
    output logic                  run_ack,
    output logic                  run_done,
    output logic                  run_err,
    output logic                  ctrl_busy,
    output logic                  npu_en_processing,
    input  logic                  npu_busy_sync
);

    localparam int             LOW_W    = (MIN_LOW < 2) ? 1 : $clog2(MIN_LOW);
    localparam logic [LOW_W-1:0] LOW_LAST = LOW_W'(MIN_LOW - 1);

    if ((TO_CYCLES < 1) || (longint'(TO_CYCLES) >= (longint'(1) << TO_W)) || (MIN_LOW < 1))
    begin : g_bad_cfg
        $error("seu_npu_launch_ctrl: TO_CYCLES must be in [1, 2**TO_W) and MIN_LOW >= 1");
    end

    state_e                state;
    state_e                state_n;
    logic [INIT_LEN_W-1:0] len_q;
    logic [INIT_LEN_W-1:0] beat_cnt;
    logic [LOW_W-1:0]      low_cnt;
    logic                  init_take;
    logic                  beat_take;
    logic                  low_done;
    logic                  to_expire;

`ifdef SEU_NPU_TIMEOUT_EN
    logic to_clr;
    logic to_run;

    assign to_clr = (state == ST_READY) && (state_n == ST_START);
    assign to_run = (state == ST_START) || (state == ST_RUN);

    seu_npu_timeout_cnt #(
        .W    (TO_W),
        .LOAD (TO_W'(TO_CYCLES - 1))
    ) u_timeout (
        .clk_trans (clk_trans),
        .rst       (rst),
        .clr       (to_clr),
        .en        (to_run),
        .expire    (to_expire)
    );
`else
    assign to_expire = 1'b0;
`endif

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_n   = state;
        init_take = init_req && (state inside {ST_IDLE, ST_LOAD, ST_READY});
        beat_take = (state == ST_LOAD) && init_wvalid && !init_req;
        low_done  = (low_cnt == LOW_LAST);

        if (init_take) begin
            // A zero-length load has nothing to transfer and completes at once.
            state_n = (init_len == '0) ? ST_READY : ST_LOAD;
        end else begin
            case (state)
                ST_IDLE:  state_n = ST_IDLE;
                ST_LOAD:  if (beat_take && (beat_cnt == len_q - INIT_LEN_W'(1))) state_n = ST_READY;
                ST_READY: if (run_req && !npu_busy_sync) state_n = ST_START;
                ST_START: begin
                    if (to_expire)          state_n = ST_ERR;
                    else if (npu_busy_sync) state_n = ST_RUN;
                end
                // Busy falling beats a coincident timeout: the run did finish.
                ST_RUN: begin
                    if (!npu_busy_sync)  state_n = ST_COOL;
                    else if (to_expire)  state_n = ST_ERR;
                end
                ST_COOL:  if (low_done && !npu_busy_sync) state_n = ST_READY;
                ST_ERR:   if (low_done && !npu_busy_sync) state_n = ST_IDLE;
                default:  state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_trans) begin
        if (rst) begin
            state             <= ST_IDLE;
            len_q             <= '0;
            beat_cnt          <= '0;
            low_cnt           <= '0;
            init_wready       <= 1'b0;
            npu_init_cmplt    <= 1'b0;
            npu_en_processing <= 1'b0;
            ctrl_busy         <= 1'b0;
            run_ack           <= 1'b0;
            run_done          <= 1'b0;
            run_err           <= 1'b0;
        end else begin
            state <= state_n;

            if (init_take) begin
                len_q    <= init_len;
                beat_cnt <= '0;
            end else if (beat_take) begin
                beat_cnt <= beat_cnt + INIT_LEN_W'(1);
            end

            // Enable-low time is measured from the edge that leaves RUN (or enters ERR).
            if ((state == ST_COOL) || (state == ST_ERR)) begin
                if (!low_done) low_cnt <= low_cnt + LOW_W'(1);
            end else begin
                low_cnt <= '0;
            end

            init_wready       <= (state_n == ST_LOAD);
            npu_init_cmplt    <= init_held(state_n);
            npu_en_processing <= en_held(state_n);
            ctrl_busy         <= !(state_n inside {ST_IDLE, ST_READY});
            run_ack           <= (state == ST_READY) && (state_n == ST_START);
            run_done          <= (state == ST_RUN) && (state_n == ST_COOL);
`ifdef SEU_NPU_TIMEOUT_EN
            run_err           <= (state != ST_ERR) && (state_n == ST_ERR);
`else
            run_err           <= 1'b0;
`endif
        end
    end

endmodule
